// File: rtl/div_freq_pkg.sv
// Shared constants and helpers for the multi-channel programmable frequency divider.
package div_freq_pkg;

  // 25 MHz board clock down to a 1 Hz blink.
  localparam int unsigned BOARD_1HZ_DIV = 25_000_000;
  localparam int unsigned DEFAULT_DIV   = BOARD_1HZ_DIV;

  // Width of the channel-select field; never narrower than one bit.
  function automatic int SEL_W(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/div_freq_chan.sv
// One divider channel: counter, shadow/active divisor pair and registered clk/tick outputs.
module div_freq_chan
  import div_freq_pkg::*;
#(
  parameter int          W        = 32,
  parameter int unsigned INIT_DIV = DEFAULT_DIV
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic         sync_i,
  input  logic         we_i,
  input  logic [W-1:0] div_i,
  output logic         clk_o,
  output logic         tick_o,
  output logic         busy_o
);

  localparam logic [W-1:0] INIT_VAL = W'(INIT_DIV);

  logic [W-1:0] r_ctr;
  logic [W-1:0] r_div_act;
  logic [W-1:0] r_div_shd;
  logic         r_pend;
  logic         r_clk;
  logic         r_tick;

  logic         w_stopped;
  logic         w_wrap;
  logic         w_apply;
  logic         w_pend_next;
  logic [W-1:0] w_shd_next;

  // A divisor of zero parks the channel; >= keeps a shrunken divisor from skipping the wrap.
  assign w_stopped   = (r_div_act == '0);
  assign w_wrap      = en_i && !w_stopped && (r_ctr >= r_div_act - W'(1));
  assign w_shd_next  = we_i ? div_i : r_div_shd;
  assign w_pend_next = we_i | r_pend;
  // A write on the wrap edge takes effect at once; a parked channel picks it up one edge later.
  assign w_apply     = (w_wrap && w_pend_next) || (w_stopped && r_pend);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ctr     <= '0;
      r_div_act <= INIT_VAL;
      r_div_shd <= INIT_VAL;
      r_pend    <= 1'b0;
      r_clk     <= 1'b1;
      r_tick    <= 1'b0;
    end else if (sync_i) begin
      r_ctr     <= '0;
      r_clk     <= 1'b1;
      r_tick    <= 1'b0;
      r_div_shd <= w_shd_next;
      r_pend    <= 1'b0;
      if (w_pend_next) begin
        r_div_act <= w_shd_next;
      end
    end else begin
      if (w_wrap) begin
        r_ctr  <= '0;
        r_tick <= 1'b1;
        r_clk  <= ~r_clk;
      end else if (en_i && !w_stopped) begin
        r_ctr  <= r_ctr + W'(1);
        r_tick <= 1'b0;
      end else begin
        r_tick <= 1'b0;
        if (w_stopped) begin
          r_ctr <= '0;
        end
      end
      r_div_shd <= w_shd_next;
      if (w_apply) begin
        r_div_act <= w_shd_next;
        r_pend    <= 1'b0;
      end else begin
        r_pend <= w_pend_next;
      end
    end
  end

  assign clk_o  = r_clk;
  assign tick_o = r_tick;
  assign busy_o = r_pend;

  a_ctr_below_div : assert property (@(posedge clk_i) disable iff (rst_i)
    (r_div_act == '0) || (r_ctr < r_div_act));

endmodule

// File: rtl/div_freq_multi.sv
// Multi-channel programmable divider: decodes the shared write port and replicates the channel.
module div_freq_multi
  import div_freq_pkg::SEL_W;
#(
  parameter int          CHANNELS    = 4,
  parameter int          W           = 32,
  parameter int unsigned DEFAULT_DIV = div_freq_pkg::DEFAULT_DIV
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [CHANNELS-1:0]        en_i,
  input  logic                       sync_i,
  input  logic                       we_i,
  input  logic [SEL_W(CHANNELS)-1:0] sel_i,
  input  logic [W-1:0]               div_i,
  output logic [CHANNELS-1:0]        clk_o,
  output logic [CHANNELS-1:0]        tick_o,
  output logic [CHANNELS-1:0]        busy_o
);

  localparam int SW = SEL_W(CHANNELS);

  logic [CHANNELS-1:0] w_we;

  // Select values with no matching channel simply decode to no write enable.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    assign w_we[c] = we_i && (sel_i == SW'(c));

    div_freq_chan #(
      .W       (W),
      .INIT_DIV(DEFAULT_DIV)
    ) u_chan (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .en_i  (en_i[c]),
      .sync_i(sync_i),
      .we_i  (w_we[c]),
      .div_i (div_i),
      .clk_o (clk_o[c]),
      .tick_o(tick_o[c]),
      .busy_o(busy_o[c])
    );
  end

endmodule

// File: doc/div_freq_multi.md
# div_freq_multi

Parametrised multi-channel programmable frequency divider, the successor to the fixed 25 M divider. Each of `CHANNELS` independent channels divides the system clock by a runtime-programmable divisor and produces both a 50 % square output and a one-cycle tick strobe. Divisor changes are glitch-free: a new value applies at the channel's next wrap. It sits between the board clock and slow consumers such as LEDs, shift registers and display scanners, and is programmed by a control FSM or switches.

## Interface
Parameters:
- `CHANNELS`, 4: number of independent divider channels (1–16).
- `W`, 32: divisor and counter width.
- `DEFAULT_DIV`, 25_000_000: divisor loaded into every channel at reset.

Ports:
- `clk_i`, in, 1: system clock; the only clock.
- `rst_i`, in, 1: reset, synchronous, active-high.
- `en_i`, in, CHANNELS: per-channel count enable.
- `sync_i`, in, 1: restart all channels phase-aligned.
- `we_i`, in, 1: divisor write strobe.
- `sel_i`, in, $clog2(CHANNELS) (min 1): target channel of the write.
- `div_i`, in, W: divisor value written.
- `clk_o`, out, CHANNELS: divided square outputs, period 2·D.
- `tick_o`, out, CHANNELS: one-cycle strobe, period D.
- `busy_o`, out, CHANNELS: a shadow divisor is pending for that channel.

## Operation
- Per channel: registers `ctr` (W), `div_act` (W), `div_shd` (W), `pend` (1), plus the `clk_o` and `tick_o` bits.
- Reset, while `rst_i` is high at an edge: `ctr`=0, `div_act`=`div_shd`=`DEFAULT_DIV`, `pend`=0, `clk_o`=1, `tick_o`=0, `busy_o`=0.
- Counting (`en_i[c]`=1, D=`div_act`≥1):
  - If `ctr`==D−1: `ctr`←0, `tick_o`←1, `clk_o`←~`clk_o`.
  - Otherwise: `ctr`←`ctr`+1, `tick_o`←0.
- D=1: `tick_o` is held high continuously; `clk_o` toggles every cycle (clk/2).
- D=0: channel is stopped. `ctr` holds 0, `tick_o`=0, `clk_o` holds its value.
- `en_i[c]`=0: `ctr` and `clk_o` freeze, `tick_o`=0. Counting resumes from the frozen `ctr`.
- Write (`we_i`=1): `div_shd[sel_i]`←`div_i`, `pend`←1.
  - `sel_i` ≥ `CHANNELS` is ignored.
  - The pending value is copied to `div_act` on the cycle that channel wraps (`ctr`==D−1 with `en_i`=1), then `pend`←0.
  - If `div_act`==0, the copy happens on the next edge.
  - A second write before the copy overwrites `div_shd`. Last write wins.
- `sync_i`=1, all channels:
  - `ctr`←0, `clk_o`←1, `tick_o`←0.
  - Any pending shadow is applied immediately and `pend`←0.
  - `sync_i` acts regardless of `en_i`.
- Priority: `rst_i` > `sync_i` > wrap/count.
  - A write and `sync_i` in the same cycle: the written value becomes `div_act` at that edge.
  - A write landing on the wrap cycle of the same channel: the new value becomes `div_act` at that edge.
- Arithmetic: `ctr` compares against `div_act`−1 computed in W bits. No overflow is possible because `ctr` < `div_act` always holds.
  - If a `div_act` change leaves `ctr` ≥ new D−1, the next edge wraps. This is unreachable by construction and covered by an assertion.

## Timing
- All outputs are registered. No combinational path from inputs to outputs.
- With D≥2 and `en_i` high after reset release, `tick_o` is high for exactly one cycle out of every D.
  - First `tick_o` is high in the cycle after the D-th rising edge with `rst_i` low.
  - `clk_o` falls at that same edge.
- `busy_o` rises the cycle after the write edge. It falls the cycle after the copy.
- New divisor latency: at most the old D cycles after the write, or 1 cycle if `sync_i` or D=0.
- Channels are fully independent except for the shared `sync_i` and the write port.

## Structure
- Package `div_freq_pkg`:
  - `DEFAULT_DIV`.
  - `SEL_W` function (clog2, min 1).
  - Localparam for the 25 MHz → 1 Hz board constant 25_000_000.
- Sub-module `div_freq_chan`: one channel (`ctr`, shadow/active registers, wrap logic, outputs).
  - The top level decodes `sel_i`/`we_i` into per-channel write enables and generates `CHANNELS` instances.

## Test plan
- Reset then `DEFAULT_DIV`=4 (param override), `en_i`=all-1 -> `tick_o[0]` pulses every 4 cycles, first after the 4th edge; `clk_o[0]` period 8, starting at 1.
- Write `div_i`=3 to ch1 while D=5 with `ctr`=1 -> `busy_o[1]`=1; old period completes (3 more cycles); next period is 3; `busy_o[1]` clears after the wrap.
- D=1 on ch2 -> `tick_o[2]` constantly 1, `clk_o[2]` toggles every cycle; then write 0 -> ch2 stops on the next edge, `clk_o` holds, `tick_o`=0.
- `en_i[0]` dropped for 10 cycles mid-count at `ctr`=2 -> outputs frozen; `tick_o` resumes exactly D−2 cycles after re-enable.
- `sync_i` pulse with ch0 D=4 and ch3 D=6 out of phase -> both `ctr`=0, `clk_o`=1; ticks coincide every 12 cycles thereafter.
- `rst_i` asserted mid-count with a pending write -> next cycle all outputs at reset values, `div_act`=`DEFAULT_DIV`, `busy_o`=0.
